pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg_if.sv | 29 ++
 rtl/pipe_stage_reg.sv | 81 ++++++++
 tb/tb_pipe_stage_reg.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// Bundle of the stall/flush controls, upstream payload and registered outputs
// exchanged between a pipeline stage register and its surrounding stages.
interface pipe_stage_reg_if #(
  parameter int DATA_W  = 32,
  parameter int STALL_W = 6,
  parameter int CNT_W   = 16
);
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic               in_valid;
  logic [DATA_W-1:0]  in_data;
  logic               in_ds_next;
  logic               cnt_clr;
  logic               out_valid;
  logic [DATA_W-1:0]  out_data;
  logic               out_ds;
  logic [CNT_W-1:0]   hold_cnt;
  logic [CNT_W-1:0]   bubble_cnt;

  modport master (
    output stall, flush, in_valid, in_data, in_ds_next, cnt_clr,
    input  out_valid, out_data, out_ds, hold_cnt, bubble_cnt
  );

  modport slave (
    input  stall, flush, in_valid, in_data, in_ds_next, cnt_clr,
    output out_valid, out_data, out_ds, hold_cnt, bubble_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: payload + valid with load/bubble/hold/flush,
// registered delay-slot feedback and saturating hold/bubble counters.
module pipe_stage_reg #(
  parameter int              DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter int              STALL_W   = 6,
  parameter int              STAGE     = 2,
  parameter int              CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pipe_stage_reg_if.slave      i_bus
);

  if (STAGE < 0 || STAGE > STALL_W - 2) begin : g_bad_stage
    $error("pipe_stage_reg: STAGE must be in 0..STALL_W-2");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_ds;
  logic [CNT_W-1:0]  r_hold_cnt;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic w_stall_here;
  logic w_stall_next;
  logic w_load;
  logic w_bubble;
  logic w_hold;

  assign w_stall_here = i_bus.stall[STAGE];
  assign w_stall_next = i_bus.stall[STAGE+1];
  assign w_load       = !i_bus.flush && !w_stall_here;
  assign w_bubble     = !i_bus.flush &&  w_stall_here && !w_stall_next;
  assign w_hold       = !i_bus.flush &&  w_stall_here &&  w_stall_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_data       <= NOP_VALUE;
      r_ds         <= 1'b0;
      r_hold_cnt   <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (i_bus.flush) begin
        r_valid <= 1'b0;
        r_data  <= NOP_VALUE;
        r_ds    <= 1'b0;
      end else if (w_load) begin
        r_valid <= i_bus.in_valid;
        r_data  <= i_bus.in_valid ? i_bus.in_data : NOP_VALUE;
        r_ds    <= i_bus.in_ds_next;
      end else if (w_bubble) begin
        // delay-slot status is kept so it survives the stall
        r_valid <= 1'b0;
        r_data  <= NOP_VALUE;
      end

      if (i_bus.cnt_clr) begin
        r_hold_cnt   <= '0;
        r_bubble_cnt <= '0;
      end else begin
        if (w_hold && r_hold_cnt != CNT_MAX) begin
          r_hold_cnt <= r_hold_cnt + 1'b1;
        end
        if (w_bubble && r_bubble_cnt != CNT_MAX) begin
          r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
      end
    end
  end

  assign i_bus.out_valid  = r_valid;
  assign i_bus.out_data   = r_data;
  assign i_bus.out_ds     = r_ds;
  assign i_bus.hold_cnt   = r_hold_cnt;
  assign i_bus.bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a default-parameter instance and a
// narrow-counter instance with a non-zero NOP value.
module tb_pipe_stage_reg;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(32), .STALL_W(6), .CNT_W(16)) ifa ();
  pipe_stage_reg_if #(.DATA_W(8),  .STALL_W(6), .CNT_W(2))  ifb ();

  pipe_stage_reg #(
    .DATA_W(32), .NOP_VALUE(32'h0), .STALL_W(6), .STAGE(2), .CNT_W(16)
  ) u_dut_a (
    .clk(clk), .rst(rst_a), .i_bus(ifa.slave)
  );

  pipe_stage_reg #(
    .DATA_W(8), .NOP_VALUE(8'hEE), .STALL_W(6), .STAGE(2), .CNT_W(2)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .i_bus(ifb.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifa.stall = '0; ifa.flush = 0; ifa.in_valid = 0; ifa.in_data = '0;
    ifa.in_ds_next = 0; ifa.cnt_clr = 0;
    ifb.stall = '0; ifb.flush = 0; ifb.in_valid = 0; ifb.in_data = '0;
    ifb.in_ds_next = 0; ifb.cnt_clr = 0;
  endtask

  task automatic reset_both();
    idle_inputs();
    rst_a = 1; rst_b = 1;
    step();
    rst_a = 0; rst_b = 0;
  endtask

  task automatic load_a(input logic [31:0] d, input logic ds);
    ifa.stall = '0; ifa.in_valid = 1; ifa.in_data = d; ifa.in_ds_next = ds;
    step();
    ifa.in_valid = 0; ifa.in_data = '0; ifa.in_ds_next = 0;
  endtask

  task automatic test_reset();
    ifa.in_valid = 1; ifa.in_data = 32'h1111_2222; ifa.in_ds_next = 1;
    ifa.flush = 1; ifa.cnt_clr = 1;
    rst_a = 1; rst_b = 1;
    step();
    rst_a = 0; rst_b = 0;
    idle_inputs();
    n_tests++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", ifa.out_valid); end
    n_tests++; if (ifa.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 00000000", ifa.out_data); end
    n_tests++; if (ifa.out_ds !== 1'b0) begin n_fail++; $display("FAIL reset_ds got %b want 0", ifa.out_ds); end
    n_tests++; if (ifa.hold_cnt !== 16'd0 || ifa.bubble_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnts got %0d/%0d want 0/0", ifa.hold_cnt, ifa.bubble_cnt); end
    n_tests++; if (ifb.out_data !== 8'hEE) begin n_fail++; $display("FAIL reset_nop_b got %h want ee", ifb.out_data); end
  endtask

  task automatic test_load();
    reset_both();
    ifa.stall = 6'b110011;  // bits other than STAGE/STAGE+1 must be ignored
    ifa.in_valid = 1; ifa.in_data = 32'hDEAD_BEEF; ifa.in_ds_next = 1;
    step();
    idle_inputs();
    n_tests++; if (ifa.out_valid !== 1'b1) begin n_fail++; $display("FAIL load_valid got %b want 1", ifa.out_valid); end
    n_tests++; if (ifa.out_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_data got %h want deadbeef", ifa.out_data); end
    n_tests++; if (ifa.out_ds !== 1'b1) begin n_fail++; $display("FAIL load_ds got %b want 1", ifa.out_ds); end
    ifa.in_valid = 0; ifa.in_data = 32'hFFFF_FFFF; ifa.in_ds_next = 1;
    step();
    idle_inputs();
    n_tests++; if (ifa.out_valid !== 1'b0 || ifa.out_data !== 32'h0 || ifa.out_ds !== 1'b1) begin n_fail++; $display("FAIL load_invalid got v=%b d=%h ds=%b want v=0 d=00000000 ds=1", ifa.out_valid, ifa.out_data, ifa.out_ds); end
    n_tests++; if (ifa.bubble_cnt !== 16'd0) begin n_fail++; $display("FAIL load_invalid_bcnt got %0d want 0", ifa.bubble_cnt); end
  endtask

  task automatic test_hold();
    reset_both();
    load_a(32'h1234_5678, 1'b0);
    ifa.stall = 6'b001100;
    ifa.in_valid = 1; ifa.in_data = 32'hFFFF_0000; ifa.in_ds_next = 1;
    repeat (3) step();
    idle_inputs();
    n_tests++; if (ifa.out_data !== 32'h1234_5678 || ifa.out_valid !== 1'b1 || ifa.out_ds !== 1'b0) begin n_fail++; $display("FAIL hold_outputs got v=%b d=%h ds=%b want v=1 d=12345678 ds=0", ifa.out_valid, ifa.out_data, ifa.out_ds); end
    n_tests++; if (ifa.hold_cnt !== 16'd3) begin n_fail++; $display("FAIL hold_cnt got %0d want 3", ifa.hold_cnt); end
    n_tests++; if (ifa.bubble_cnt !== 16'd0) begin n_fail++; $display("FAIL hold_bcnt got %0d want 0", ifa.bubble_cnt); end
  endtask

  task automatic test_bubble();
    reset_both();
    load_a(32'hA5A5_A5A5, 1'b1);
    ifa.stall = 6'b000100;
    ifa.in_valid = 1; ifa.in_data = 32'h0F0F_0F0F; ifa.in_ds_next = 0;
    repeat (2) step();
    idle_inputs();
    n_tests++; if (ifa.out_valid !== 1'b0 || ifa.out_data !== 32'h0) begin n_fail++; $display("FAIL bubble_payload got v=%b d=%h want v=0 d=00000000", ifa.out_valid, ifa.out_data); end
    n_tests++; if (ifa.out_ds !== 1'b1) begin n_fail++; $display("FAIL bubble_ds got %b want 1", ifa.out_ds); end
    n_tests++; if (ifa.bubble_cnt !== 16'd2 || ifa.hold_cnt !== 16'd0) begin n_fail++; $display("FAIL bubble_cnts got b=%0d h=%0d want b=2 h=0", ifa.bubble_cnt, ifa.hold_cnt); end
  endtask

  task automatic test_flush();
    reset_both();
    load_a(32'hCAFE_F00D, 1'b1);
    ifa.stall = 6'b001100;
    step();
    ifa.flush = 1;
    step();
    idle_inputs();
    n_tests++; if (ifa.out_valid !== 1'b0 || ifa.out_data !== 32'h0 || ifa.out_ds !== 1'b0) begin n_fail++; $display("FAIL flush_outputs got v=%b d=%h ds=%b want v=0 d=00000000 ds=0", ifa.out_valid, ifa.out_data, ifa.out_ds); end
    n_tests++; if (ifa.hold_cnt !== 16'd1 || ifa.bubble_cnt !== 16'd0) begin n_fail++; $display("FAIL flush_cnts got h=%0d b=%0d want h=1 b=0", ifa.hold_cnt, ifa.bubble_cnt); end
    ifa.stall = 6'b000100; ifa.flush = 1;
    step();
    idle_inputs();
    n_tests++; if (ifa.bubble_cnt !== 16'd0) begin n_fail++; $display("FAIL flush_bubble_cnt got %0d want 0", ifa.bubble_cnt); end
  endtask

  task automatic test_saturate();
    reset_both();
    ifb.in_valid = 1; ifb.in_data = 8'h3C; ifb.in_ds_next = 1;
    step();
    ifb.in_valid = 0; ifb.in_data = 8'h00; ifb.in_ds_next = 0;
    ifb.stall = 6'b001100;
    repeat (5) step();
    n_tests++; if (ifb.hold_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_hold got %0d want 3", ifb.hold_cnt); end
    n_tests++; if (ifb.out_data !== 8'h3C || ifb.out_valid !== 1'b1 || ifb.out_ds !== 1'b1) begin n_fail++; $display("FAIL sat_outputs got v=%b d=%h ds=%b want v=1 d=3c ds=1", ifb.out_valid, ifb.out_data, ifb.out_ds); end
    ifb.cnt_clr = 1;
    step();
    ifb.cnt_clr = 0;
    n_tests++; if (ifb.hold_cnt !== 2'd0) begin n_fail++; $display("FAIL clr_hold got %0d want 0", ifb.hold_cnt); end
    n_tests++; if (ifb.out_data !== 8'h3C || ifb.out_valid !== 1'b1) begin n_fail++; $display("FAIL clr_payload got v=%b d=%h want v=1 d=3c", ifb.out_valid, ifb.out_data); end
    step();
    n_tests++; if (ifb.hold_cnt !== 2'd1) begin n_fail++; $display("FAIL clr_then_hold got %0d want 1", ifb.hold_cnt); end
    ifb.stall = 6'b000100;
    repeat (4) step();
    n_tests++; if (ifb.bubble_cnt !== 2'd3 || ifb.out_data !== 8'hEE || ifb.out_valid !== 1'b0) begin n_fail++; $display("FAIL sat_bubble got b=%0d d=%h v=%b want b=3 d=ee v=0", ifb.bubble_cnt, ifb.out_data, ifb.out_valid); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_hold();
    reset_both();
    load_a(32'h7777_8888, 1'b1);
    ifa.stall = 6'b001100;
    repeat (2) step();
    n_tests++; if (ifa.hold_cnt !== 16'd2) begin n_fail++; $display("FAIL pre_rst_hold got %0d want 2", ifa.hold_cnt); end
    rst_a = 1; ifa.flush = 1;
    step();
    rst_a = 0; ifa.flush = 0;
    n_tests++; if (ifa.out_valid !== 1'b0 || ifa.out_data !== 32'h0 || ifa.out_ds !== 1'b0 || ifa.hold_cnt !== 16'd0 || ifa.bubble_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_mid_hold got v=%b d=%h ds=%b h=%0d b=%0d want all zero", ifa.out_valid, ifa.out_data, ifa.out_ds, ifa.hold_cnt, ifa.bubble_cnt); end
    load_a(32'h0000_0001, 1'b0);
    n_tests++; if (ifa.out_data !== 32'h1 || ifa.out_valid !== 1'b1) begin n_fail++; $display("FAIL post_rst_load got v=%b d=%h want v=1 d=00000001", ifa.out_valid, ifa.out_data); end
  endtask

  task automatic test_back_to_back();
    reset_both();
    load_a(32'h0000_00A1, 1'b0);
    n_tests++; if (ifa.out_data !== 32'hA1) begin n_fail++; $display("FAIL b2b_first got %h want 000000a1", ifa.out_data); end
    load_a(32'h0000_00B2, 1'b1);
    n_tests++; if (ifa.out_data !== 32'hB2 || ifa.out_ds !== 1'b1) begin n_fail++; $display("FAIL b2b_second got d=%h ds=%b want d=000000b2 ds=1", ifa.out_data, ifa.out_ds); end
  endtask

  initial begin
    rst_a = 1; rst_b = 1;
    idle_inputs();
    step();
    test_reset();
    test_load();
    test_hold();
    test_bubble();
    test_flush();
    test_saturate();
    test_reset_mid_hold();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
